// File: rtl/store_check_monitor.sv
// Store-stream checker: compares observed data-memory writes against a loaded table of expected stores.
// Optional idle timeout enabled by defining STORE_CHECK_TIMEOUT_EN.
module store_check_monitor #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_DEPTH      = 64,
    parameter int MP_IDX_WIDTH  = 6,
    parameter int MP_ORDERED    = 1,
    parameter int MP_IGN_BASE   = 96,
    parameter int MP_IGN_SIZE   = 4,
    parameter int MP_END_ADDR   = 40,
    parameter int MP_END_DATA   = 30,
    parameter int MP_TIMEOUT    = 1024
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     iexp_we,
    input  logic [MP_DATA_WIDTH-1:0] iexp_addr,
    input  logic [MP_DATA_WIDTH-1:0] iexp_data,
    input  logic                     istart,
    input  logic                     imem_wr,
    input  logic [MP_DATA_WIDTH-1:0] iaddr,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic [1:0]               ostate,
    output logic [MP_IDX_WIDTH:0]    oexp_cnt,
    output logic [MP_IDX_WIDTH:0]    opass_cnt,
    output logic                     odone,
    output logic                     opass,
    output logic [1:0]               ofail_code,
    output logic [MP_DATA_WIDTH-1:0] ofail_addr,
    output logic [MP_DATA_WIDTH-1:0] ofail_data
);

    localparam int LP_CNT_W = MP_IDX_WIDTH + 1;
    localparam logic [LP_CNT_W-1:0]      LP_DEPTH    = LP_CNT_W'(MP_DEPTH);
    localparam logic [MP_DATA_WIDTH-1:0] LP_IGN_LO   = MP_DATA_WIDTH'(MP_IGN_BASE);
    localparam logic [MP_DATA_WIDTH:0]   LP_IGN_HI   = (MP_DATA_WIDTH+1)'(MP_IGN_BASE + MP_IGN_SIZE);
    localparam logic [MP_DATA_WIDTH-1:0] LP_END_ADDR = MP_DATA_WIDTH'(MP_END_ADDR);
    localparam logic [MP_DATA_WIDTH-1:0] LP_END_DATA = MP_DATA_WIDTH'(MP_END_DATA);

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_PASS = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    state_t r_state, w_next_state;

    logic [MP_DATA_WIDTH-1:0] r_tab_addr [MP_DEPTH];
    logic [MP_DATA_WIDTH-1:0] r_tab_data [MP_DEPTH];
    logic [MP_DEPTH-1:0]      r_matched;
    logic [MP_DEPTH-1:0]      w_match;
    logic [LP_CNT_W-1:0]      r_exp_cnt, r_pass_cnt;
    logic                     r_done, r_pass;
    logic [1:0]               r_fail_code, w_fail_code;
    logic [MP_DATA_WIDTH-1:0] r_fail_addr, r_fail_data;
    logic                     w_sentinel, w_ignored, w_load_wr;
    logic                     w_ord_hit, w_unord_hit, w_hit, w_take, w_timeout;
    logic [MP_IDX_WIDTH-1:0]  w_rd_idx, w_hit_idx;

    assign w_load_wr  = (r_state == S_LOAD) && iexp_we && (r_exp_cnt < LP_DEPTH);
    assign w_sentinel = (iaddr == LP_END_ADDR) && (iwdata == LP_END_DATA);
    assign w_ignored  = (iaddr >= LP_IGN_LO) && ({1'b0, iaddr} < LP_IGN_HI);

    // In ordered mode the pass count doubles as the read pointer into the table.
    assign w_rd_idx  = r_pass_cnt[MP_IDX_WIDTH-1:0];
    assign w_ord_hit = (r_pass_cnt < r_exp_cnt) &&
                       (r_tab_addr[w_rd_idx] == iaddr) && (r_tab_data[w_rd_idx] == iwdata);

    for (genvar g = 0; g < MP_DEPTH; g++) begin : g_match
        assign w_match[g] = !r_matched[g] && (LP_CNT_W'(g) < r_exp_cnt) &&
                            (r_tab_addr[g] == iaddr) && (r_tab_data[g] == iwdata);
    end

    // Lowest-index unmatched entry wins so duplicates are consumed in table order.
    always_comb begin
        w_unord_hit = |w_match;
        w_hit_idx   = '0;
        for (int i = MP_DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = MP_IDX_WIDTH'(i);
            end
        end
    end

    assign w_hit = (MP_ORDERED != 0) ? w_ord_hit : w_unord_hit;

`ifdef STORE_CHECK_TIMEOUT_EN
    localparam int LP_TO_W = $clog2(MP_TIMEOUT + 1);
    logic [LP_TO_W-1:0] r_idle_cnt;

    assign w_timeout = (r_state == S_RUN) && !imem_wr &&
                       (r_idle_cnt == LP_TO_W'(MP_TIMEOUT - 1));

    always_ff @(posedge iclk) begin
        if (irst || (r_state != S_RUN) || imem_wr || (w_next_state != S_RUN)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (MP_TIMEOUT != 0);
`endif

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_fail_code  = 2'd0;
        case (r_state)
            S_LOAD: begin
                if (istart) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (imem_wr) begin
                    if (w_sentinel) begin
                        if (r_pass_cnt == r_exp_cnt) begin
                            w_next_state = S_PASS;
                        end else begin
                            w_next_state = S_FAIL;
                            w_fail_code  = 2'd2;
                        end
                    end else if (!w_ignored) begin
                        if (w_hit) begin
                            w_take = 1'b1;
                        end else begin
                            w_next_state = S_FAIL;
                            w_fail_code  = 2'd1;
                        end
                    end
                end else if (w_timeout) begin
                    w_next_state = S_FAIL;
                    w_fail_code  = 2'd3;
                end
            end
            default: begin
            end
        endcase
    end

    // Table storage carries no reset; entries above oexp_cnt are never consulted.
    always_ff @(posedge iclk) begin
        if (w_load_wr) begin
            r_tab_addr[r_exp_cnt[MP_IDX_WIDTH-1:0]] <= iexp_addr;
            r_tab_data[r_exp_cnt[MP_IDX_WIDTH-1:0]] <= iexp_data;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_exp_cnt   <= '0;
            r_pass_cnt  <= '0;
            r_matched   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 2'd0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            if (w_load_wr) begin
                r_exp_cnt <= r_exp_cnt + 1'b1;
            end
            if (w_take) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
                if (MP_ORDERED == 0) begin
                    r_matched[w_hit_idx] <= 1'b1;
                end
            end
            if (w_fail_code != 2'd0) begin
                r_fail_code <= w_fail_code;
                r_fail_addr <= (w_fail_code == 2'd1) ? iaddr  : '0;
                r_fail_data <= (w_fail_code == 2'd1) ? iwdata : '0;
            end
            r_done <= (w_next_state == S_PASS) || (w_next_state == S_FAIL);
            r_pass <= (w_next_state == S_PASS);
        end
    end

    assign ostate     = r_state;
    assign oexp_cnt   = r_exp_cnt;
    assign opass_cnt  = r_pass_cnt;
    assign odone      = r_done;
    assign opass      = r_pass;
    assign ofail_code = r_fail_code;
    assign ofail_addr = r_fail_addr;
    assign ofail_data = r_fail_data;

endmodule

// File: tb/tb_store_check_monitor.sv
// Bench for store_check_monitor: an ordered and an unordered instance share one stimulus stream
// and are checked every cycle against a list-based model, plus literal expectations.
module tb_store_check_monitor;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 8;

    logic        iclk = 1'b0;
    logic        irst, iexp_we, istart, imem_wr;
    logic [31:0] iexp_addr, iexp_data, iaddr, iwdata;

    logic [1:0]  dState [2];
    logic [6:0]  dExp   [2];
    logic [6:0]  dPass  [2];
    logic        dDone  [2];
    logic        dPassF [2];
    logic [1:0]  dCode  [2];
    logic [31:0] dFA    [2];
    logic [31:0] dFD    [2];

    int testsRun    = 0;
    int testsFailed = 0;
    bit compareOn   = 1'b0;

    logic [31:0] mA [2][DEPTH];
    logic [31:0] mD [2][DEPTH];
    bit          mUsed [2][DEPTH];
    int          mExp [2], mPass [2], mState [2], mCode [2], mIdle [2];
    logic [31:0] mFA [2], mFD [2];

    always #5 iclk = ~iclk;

    store_check_monitor #(.MP_ORDERED(1), .MP_TIMEOUT(TIMEOUT)) dutOrdered (
        .iclk(iclk), .irst(irst), .iexp_we(iexp_we), .iexp_addr(iexp_addr),
        .iexp_data(iexp_data), .istart(istart), .imem_wr(imem_wr), .iaddr(iaddr),
        .iwdata(iwdata), .ostate(dState[0]), .oexp_cnt(dExp[0]), .opass_cnt(dPass[0]),
        .odone(dDone[0]), .opass(dPassF[0]), .ofail_code(dCode[0]),
        .ofail_addr(dFA[0]), .ofail_data(dFD[0])
    );

    store_check_monitor #(.MP_ORDERED(0), .MP_TIMEOUT(TIMEOUT)) dutUnordered (
        .iclk(iclk), .irst(irst), .iexp_we(iexp_we), .iexp_addr(iexp_addr),
        .iexp_data(iexp_data), .istart(istart), .imem_wr(imem_wr), .iaddr(iaddr),
        .iwdata(iwdata), .ostate(dState[1]), .oexp_cnt(dExp[1]), .opass_cnt(dPass[1]),
        .odone(dDone[1]), .opass(dPassF[1]), .ofail_code(dCode[1]),
        .ofail_addr(dFA[1]), .ofail_data(dFD[1])
    );

    task automatic checkOutput(input string name, input int m,
                               input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s[%0d]: got %0d expected %0d", name, m, actual, expected);
        end
    endtask

    task automatic modelFail(input int m, input int code, input logic [31:0] a, input logic [31:0] d);
        mState[m] = 3;
        mCode[m]  = code;
        mFA[m]    = a;
        mFD[m]    = d;
    endtask

    // Model: expected stores are a list; ordered mode consumes its head, unordered mode
    // consumes the first not-yet-seen equal entry.
    task automatic modelStep(input int m);
        int k;
        if (irst) begin
            mState[m] = 0; mExp[m] = 0; mPass[m] = 0; mCode[m] = 0; mIdle[m] = 0;
            mFA[m] = 0; mFD[m] = 0;
            for (int j = 0; j < DEPTH; j++) mUsed[m][j] = 1'b0;
        end else if (mState[m] == 0) begin
            if (iexp_we && mExp[m] < DEPTH) begin
                mA[m][mExp[m]] = iexp_addr;
                mD[m][mExp[m]] = iexp_data;
                mExp[m]++;
            end
            if (istart) mState[m] = 1;
        end else if (mState[m] == 1) begin
            if (imem_wr) begin
                mIdle[m] = 0;
                if (iaddr == 40 && iwdata == 30) begin
                    if (mPass[m] == mExp[m]) mState[m] = 2;
                    else modelFail(m, 2, 0, 0);
                end else if (!(iaddr >= 96 && iaddr < 100)) begin
                    k = -1;
                    if (m == 0) begin
                        if (mPass[m] < mExp[m] && mA[m][mPass[m]] == iaddr && mD[m][mPass[m]] == iwdata)
                            k = mPass[m];
                    end else begin
                        for (int j = mExp[m] - 1; j >= 0; j--)
                            if (!mUsed[m][j] && mA[m][j] == iaddr && mD[m][j] == iwdata) k = j;
                    end
                    if (k >= 0) begin
                        mUsed[m][k] = 1'b1;
                        mPass[m]++;
                    end else begin
                        modelFail(m, 1, iaddr, iwdata);
                    end
                end
            end else begin
`ifdef STORE_CHECK_TIMEOUT_EN
                mIdle[m]++;
                if (mIdle[m] == TIMEOUT) modelFail(m, 3, 0, 0);
`endif
            end
        end
    endtask

    always @(posedge iclk) begin
        modelStep(0);
        modelStep(1);
    end

    always @(negedge iclk) begin
        if (compareOn) begin
            for (int m = 0; m < 2; m++) begin
                checkOutput("ostate", m, 32'(dState[m]), 32'(mState[m]));
                checkOutput("oexp_cnt", m, 32'(dExp[m]), 32'(mExp[m]));
                checkOutput("opass_cnt", m, 32'(dPass[m]), 32'(mPass[m]));
                checkOutput("odone", m, 32'(dDone[m]), 32'(mState[m] >= 2));
                checkOutput("opass", m, 32'(dPassF[m]), 32'(mState[m] == 2));
                checkOutput("ofail_code", m, 32'(dCode[m]), 32'(mCode[m]));
                checkOutput("ofail_addr", m, dFA[m], mFA[m]);
                checkOutput("ofail_data", m, dFD[m], mFD[m]);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] ea,
                                 input logic [31:0] ed, input logic start, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d);
        irst = rst; iexp_we = we; iexp_addr = ea; iexp_data = ed;
        istart = start; imem_wr = wr; iaddr = a; iwdata = d;
        @(posedge iclk);
        #1;
    endtask

    task automatic doReset();        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic loadEntry(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(0, 1, a, d, 0, 0, 0, 0);
    endtask
    task automatic startRun();       applyStimulus(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic storeOp(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(0, 0, 0, 0, 0, 1, a, d);
    endtask
    task automatic idleCycle();      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic loadBasic();
        loadEntry(100, 25);
        loadEntry(104, 4096);
        loadEntry(108, 4184);
    endtask

    initial begin
        doReset();
        compareOn = 1'b1;
        for (int m = 0; m < 2; m++) begin
            checkOutput("lit_reset_state", m, 32'(dState[m]), 0);
            checkOutput("lit_reset_done", m, 32'(dDone[m]), 0);
        end

        // Ordered pass; a store during LOAD must be ignored
        storeOp(100, 25);
        loadBasic();
        startRun();
        storeOp(100, 25);
        storeOp(104, 4096);
        storeOp(108, 4184);
        storeOp(40, 30);
        checkOutput("lit_t1_state", 0, 32'(dState[0]), 2);
        checkOutput("lit_t1_opass", 0, 32'(dPassF[0]), 1);
        checkOutput("lit_t1_passcnt", 0, 32'(dPass[0]), 3);
        idleCycle();

        // Ordered data mismatch
        doReset();
        loadBasic();
        startRun();
        storeOp(100, 25);
        storeOp(104, 4095);
        checkOutput("lit_t2_state", 0, 32'(dState[0]), 3);
        checkOutput("lit_t2_code", 0, 32'(dCode[0]), 1);
        checkOutput("lit_t2_addr", 0, dFA[0], 104);
        checkOutput("lit_t2_data", 0, dFD[0], 4095);
        checkOutput("lit_t2_passcnt", 0, 32'(dPass[0]), 1);
        idleCycle();

        // Ignore window plus early sentinel
        doReset();
        loadBasic();
        startRun();
        storeOp(96, 7);
        storeOp(100, 25);
        storeOp(99, 1234);
        storeOp(97, 0);
        storeOp(98, 25);
        checkOutput("lit_t3_running", 0, 32'(dState[0]), 1);
        storeOp(40, 30);
        checkOutput("lit_t3_state", 0, 32'(dState[0]), 3);
        checkOutput("lit_t3_code", 0, 32'(dCode[0]), 2);
        checkOutput("lit_t3_passcnt", 0, 32'(dPass[0]), 1);
        checkOutput("lit_t3_addr", 0, dFA[0], 0);
        idleCycle();

        // Unordered with duplicates; the ordered instance fails on the first store
        doReset();
        loadEntry(100, 25); loadEntry(100, 25); loadEntry(104, 1);
        startRun();
        storeOp(104, 1);
        storeOp(100, 25);
        storeOp(100, 25);
        storeOp(40, 30);
        checkOutput("lit_t4_state", 1, 32'(dState[1]), 2);
        checkOutput("lit_t4_passcnt", 1, 32'(dPass[1]), 3);
        checkOutput("lit_t4_ord_code", 0, 32'(dCode[0]), 1);
        checkOutput("lit_t4_ord_addr", 0, dFA[0], 104);
        idleCycle();

        doReset();
        loadEntry(100, 25); loadEntry(100, 25); loadEntry(104, 1);
        startRun();
        storeOp(104, 1);
        storeOp(100, 25);
        storeOp(100, 25);
        storeOp(100, 25);
        checkOutput("lit_t4b_state", 1, 32'(dState[1]), 3);
        checkOutput("lit_t4b_code", 1, 32'(dCode[1]), 1);
        checkOutput("lit_t4b_data", 1, dFD[1], 25);
        storeOp(40, 30);
        checkOutput("lit_t4b_hold", 1, 32'(dState[1]), 3);

        // Saturation, then reset mid-RUN
        doReset();
        for (int i = 0; i < DEPTH + 2; i++) loadEntry(32'(200 + 4 * i), 32'(i));
        checkOutput("lit_t5_sat", 0, 32'(dExp[0]), 64);
        startRun();
        storeOp(200, 0);
        checkOutput("lit_t5_passcnt", 1, 32'(dPass[1]), 1);
        doReset();
        for (int m = 0; m < 2; m++) begin
            checkOutput("lit_t5_rst_state", m, 32'(dState[m]), 0);
            checkOutput("lit_t5_rst_exp", m, 32'(dExp[m]), 0);
            checkOutput("lit_t5_rst_pass", m, 32'(dPass[m]), 0);
        end

        // Load and start in the same cycle; RUN ignores further loads and starts
        applyStimulus(0, 1, 100, 25, 1, 0, 0, 0);
        checkOutput("lit_t7_exp", 0, 32'(dExp[0]), 1);
        checkOutput("lit_t7_state", 0, 32'(dState[0]), 1);
        applyStimulus(0, 1, 104, 4, 1, 0, 0, 0);
        checkOutput("lit_t7_noload", 0, 32'(dExp[0]), 1);
        storeOp(100, 25);
        storeOp(40, 30);
        checkOutput("lit_t7_pass", 0, 32'(dState[0]), 2);

        // Empty table passes straight to the sentinel
        doReset();
        startRun();
        storeOp(40, 30);
        checkOutput("lit_t8_pass", 1, 32'(dState[1]), 2);

        // Idle timeout, restarted by a window store
        doReset();
        loadEntry(100, 25);
        startRun();
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle();
        checkOutput("lit_t6_alive1", 0, 32'(dState[0]), 1);
        storeOp(96, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle();
        checkOutput("lit_t6_alive2", 0, 32'(dState[0]), 1);
        idleCycle();
`ifdef STORE_CHECK_TIMEOUT_EN
        checkOutput("lit_t6_state", 0, 32'(dState[0]), 3);
        checkOutput("lit_t6_code", 0, 32'(dCode[0]), 3);
`else
        checkOutput("lit_t6_state", 0, 32'(dState[0]), 1);
        checkOutput("lit_t6_code", 0, 32'(dCode[0]), 0);
`endif
        idleCycle();
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
